// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract unit with per-beat opcode, carry and
// overflow flags, valid/ready flow control on both sides and a synchronous flush.
// The whole pipeline stalls as one when the output beat is not accepted.
module addsub_pipe #(
   parameter int W      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         carry,
   output logic         ovf
);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_SADD = 2'b11;

   // Result registers after the arithmetic; the last one drives the outputs.
   localparam int ND = (STAGES > 1) ? STAGES - 1 : 1;

   logic         w_advance;
   logic [W-1:0] w_a;
   logic [W-1:0] w_b;
   logic [1:0]   w_op;
   logic         w_v;
   logic         w_cin;
   logic [W:0]   w_sum;
   logic [W:0]   w_diff;
   logic [W-1:0] w_y;
   logic         w_c;
   logic         w_o;

   logic [W-1:0] r_y [ND];
   logic         r_c [ND];
   logic         r_o [ND];
   logic         r_v [ND];

   assign w_advance = !r_v[ND-1] || out_ready;
   assign in_ready  = w_advance;

   generate
      if (STAGES == 1) begin : g_direct
         assign w_a  = a;
         assign w_b  = b;
         assign w_op = op;
         assign w_v  = in_valid;
      end else begin : g_opreg
         logic [W-1:0] r_a;
         logic [W-1:0] r_b;
         logic [1:0]   r_op;
         logic         r_v1;

         // Operand stage: capture the offered beat; flush only kills the valid bit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a  <= '0;
               r_b  <= '0;
               r_op <= '0;
               r_v1 <= 1'b0;
            end else begin
               if (flush)
                  r_v1 <= 1'b0;
               else if (w_advance)
                  r_v1 <= in_valid;
               if (w_advance && !flush) begin
                  r_a  <= a;
                  r_b  <= b;
                  r_op <= op;
               end
            end
         end

         assign w_a  = r_a;
         assign w_b  = r_b;
         assign w_op = r_op;
         assign w_v  = r_v1;
      end
   endgenerate

   // Arithmetic at W+1 bits; SADD clamps on unsigned carry-out, the rest wrap.
   always_comb begin
      w_cin  = (w_op == OP_INC);
      w_sum  = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};
      w_diff = {1'b0, w_a} - {1'b0, w_b};
      w_y    = w_sum[W-1:0];
      w_c    = w_sum[W];
      w_o    = (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);
      case (w_op)
         OP_ADD, OP_INC: ;
         OP_SUB: begin
            w_y = w_diff[W-1:0];
            w_c = w_diff[W];
            w_o = (w_a[W-1] != w_b[W-1]) && (w_diff[W-1] != w_a[W-1]);
         end
         OP_SADD: begin
            if (w_sum[W]) begin
               w_y = '1;
               w_c = 1'b1;
               w_o = 1'b1;
            end else begin
               w_y = w_sum[W-1:0];
               w_c = 1'b0;
               w_o = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Result delay line: shifts only on advance, flush clears valids but keeps data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ND; i++) begin
            r_y[i] <= '0;
            r_c[i] <= 1'b0;
            r_o[i] <= 1'b0;
            r_v[i] <= 1'b0;
         end
      end else begin
         if (flush) begin
            for (int i = 0; i < ND; i++)
               r_v[i] <= 1'b0;
         end else if (w_advance) begin
            r_v[0] <= w_v;
            for (int i = 1; i < ND; i++)
               r_v[i] <= r_v[i-1];
         end
         if (w_advance && !flush) begin
            r_y[0] <= w_y;
            r_c[0] <= w_c;
            r_o[0] <= w_o;
            for (int i = 1; i < ND; i++) begin
               r_y[i] <= r_y[i-1];
               r_c[i] <= r_c[i-1];
               r_o[i] <= r_o[i-1];
            end
         end
      end
   end

   assign out_valid = r_v[ND-1];
   assign y         = r_y[ND-1];
   assign carry     = r_c[ND-1];
   assign ovf       = r_o[ND-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three instances (STAGES = 2, 1, 4) share operands,
// flush and reset; a driver pushes expected results into per-instance queues
// and independent monitors pop and compare whenever a result is consumed.
module tb_addsub_pipe;

   logic       clk = 1'b0;
   logic       rst_n, flush;
   logic [1:0] op;
   logic [7:0] a, b;
   logic       iv0, iv1, iv2;
   logic       or0, or12;
   logic       ir0, ir1, ir2;
   logic       ov0, ov1, ov2;
   logic [7:0] y0, y1, y2;
   logic       c0, c1, c2;
   logic       f0, f1, f2;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [42:0] q0[$];
   logic [42:0] q1[$];
   logic [42:0] q2[$];
   logic [9:0]  snap;

   // {op, a, b, {y, carry, ovf}}
   localparam logic [27:0] VEC [12] = '{
      {2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
      {2'b01, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0},
      {2'b10, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0},
      {2'b10, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
      {2'b11, 8'hF0, 8'h20, 8'hFF, 1'b1, 1'b1},
      {2'b11, 8'h40, 8'h20, 8'h60, 1'b0, 1'b0},
      {2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},
      {2'b01, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1},
      {2'b11, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0},
      {2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1},
      {2'b10, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1},
      {2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0}
   };

   addsub_pipe #(.W(8), .STAGES(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv0), .in_ready(ir0),
      .op(op), .a(a), .b(b), .out_valid(ov0), .out_ready(or0),
      .y(y0), .carry(c0), .ovf(f0));

   addsub_pipe #(.W(8), .STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
      .op(op), .a(a), .b(b), .out_valid(ov1), .out_ready(or12),
      .y(y1), .carry(c1), .ovf(f1));

   addsub_pipe #(.W(8), .STAGES(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv2), .in_ready(ir2),
      .op(op), .a(a), .b(b), .out_valid(ov2), .out_ready(or12),
      .y(y2), .carry(c2), .ovf(f2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   function automatic logic ir_of(input int d);
      return (d == 0) ? ir0 : ((d == 1) ? ir1 : ir2);
   endfunction

   task automatic setiv(input int d, input logic v);
      case (d)
         0: iv0 = v;
         1: iv1 = v;
         default: iv2 = v;
      endcase
   endtask

   task automatic push(input int d, input logic [42:0] e);
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic mon(input int d, input logic [7:0] yy, input logic cc, input logic oo);
      logic [42:0] e = '0;
      bit have = 1'b0;
      case (d)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL unexpected_result dut%0d: got y=%0h with nothing outstanding (t=%0t)",
                  d, yy, $time);
      end else begin
         chk($sformatf("result dut%0d {y,carry,ovf}", d), 32'({yy, cc, oo}), 32'(e[9:0]));
         if (e[42])
            chk($sformatf("latency dut%0d", d), 32'(cyc - int'(e[41:10])), 32'(lat(d)));
      end
   endtask

   // Offer one beat on instance d and wait (bounded) for it to be accepted.
   task automatic send(input int d, input logic [1:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [9:0] e, input bit lc,
                       input bit dopush);
      int n = 0;
      @(negedge clk);
      op = o; a = aa; b = bb;
      setiv(d, 1'b1);
      while (!ir_of(d) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout dut%0d: in_ready stayed 0 for 50 cycles, required 1", d);
         setiv(d, 1'b0);
      end else begin
         @(posedge clk);
         #1;
         setiv(d, 1'b0);
         if (dopush) push(d, {lc, 32'(cyc), e});
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results still outstanding, required 0",
                  q0.size() + q1.size() + q2.size());
         q0.delete(); q1.delete(); q2.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   always @(negedge clk) if (rst_n && ov0 && or0)  mon(0, y0, c0, f0);
   always @(negedge clk) if (rst_n && ov1 && or12) mon(1, y1, c1, f1);
   always @(negedge clk) if (rst_n && ov2 && or12) mon(2, y2, c2, f2);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; or0 = 1'b1; or12 = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset y", 32'(y0), 32'h0);
      chk("reset {carry,ovf,out_valid}", 32'({c0, f0, ov0}), 32'h0);
      chk("reset in_ready", 32'(ir0), 32'h1);
      chk("reset out_valid stages4", 32'(ov2), 32'h0);
      rst_n = 1'b1;

      // Every vector in isolation on the default depth, with latency check.
      for (int i = 0; i < 12; i++) begin
         send(0, VEC[i][27:26], VEC[i][25:18], VEC[i][17:10], VEC[i][9:0], 1'b1, 1'b1);
         drain();
      end

      // Depth sweep: STAGES = 1 and 4 on the first two vectors.
      for (int d = 1; d < 3; d++) begin
         for (int i = 0; i < 2; i++) begin
            send(d, VEC[i][27:26], VEC[i][25:18], VEC[i][17:10], VEC[i][9:0], 1'b1, 1'b1);
            drain();
         end
      end

      // Back-to-back throughput on STAGES = 2 and 4.
      for (int i = 0; i < 12; i++)
         send(0, VEC[i][27:26], VEC[i][25:18], VEC[i][17:10], VEC[i][9:0], 1'b0, 1'b1);
      drain();
      for (int i = 0; i < 12; i++)
         send(2, VEC[i][27:26], VEC[i][25:18], VEC[i][17:10], VEC[i][9:0], 1'b0, 1'b1);
      drain();

      // Backpressure: 6 ADD beats with out_ready low for 3 cycles mid-stream.
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(0, 2'b00, 8'(i), 8'h01, {8'(i + 1), 2'b00}, 1'b0, 1'b1);
         end
         begin
            repeat (3) @(posedge clk);
            #1 or0 = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("stall in_ready", 32'(ir0), 32'h0);
               chk("stall out_valid", 32'(ov0), 32'h1);
               if (k == 0) snap = {y0, c0, f0};
               else chk("stall hold {y,carry,ovf}", 32'({y0, c0, f0}), 32'(snap));
            end
            @(posedge clk);
            #1 or0 = 1'b1;
         end
      join
      drain();

      // Flush with two beats in flight plus a beat offered in the flush cycle.
      or0 = 1'b0;
      send(0, 2'b00, 8'h11, 8'h22, 10'h0, 1'b0, 1'b0);
      send(0, 2'b00, 8'h33, 8'h44, 10'h0, 1'b0, 1'b0);
      @(negedge clk);
      flush = 1'b1; op = 2'b00; a = 8'h55; b = 8'h01; iv0 = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0; iv0 = 1'b0; or0 = 1'b1;
      @(negedge clk);
      chk("flush out_valid", 32'(ov0), 32'h0);
      repeat (5) @(negedge clk);
      send(0, 2'b00, 8'h11, 8'h22, {8'h33, 2'b00}, 1'b1, 1'b1);
      drain();

      // Reset with beats in flight.
      or0 = 1'b0;
      send(0, 2'b00, 8'h01, 8'h02, 10'h0, 1'b0, 1'b0);
      send(0, 2'b10, 8'h05, 8'h03, 10'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset y", 32'(y0), 32'h0);
      chk("midreset {carry,ovf,out_valid}", 32'({c0, f0, ov0}), 32'h0);
      chk("midreset in_ready", 32'(ir0), 32'h1);
      @(negedge clk);
      rst_n = 1'b1; or0 = 1'b1;
      repeat (3) @(negedge clk);
      send(0, 2'b10, 8'h10, 8'h20, {8'hF0, 1'b1, 1'b0}, 1'b1, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
